cfg_bank_ctrl: RTL and testbench

// Double-buffered config register controller behind the UART packet receiver.

---
 rtl/cfg_bank_ctrl_if.sv | 30 +++
 rtl/cfg_bank_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cfg_bank_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cfg_bank_ctrl_if.sv
// Bundles the byte-load strobes, the active-bank read port and the status flags of cfg_bank_ctrl.
// The master side is the packet source and raster reader; the slave side is the controller.
interface cfg_bank_ctrl_if #(
  parameter int IDXW = 6
);
  logic            update_reg;
  logic [IDXW-1:0] idx;
  logic [7:0]      read_data;
  logic            pc_ready;
  logic            frame_start;
  logic            clear_err;
  logic [IDXW-1:0] rd_idx;
  logic [7:0]      rd_data;
  logic            cfg_valid;
  logic            frame_commit;
  logic            busy;
  logic            seq_err;
  logic            tmo_err;
  logic            ovr_err;

  modport master (
    output update_reg, idx, read_data, pc_ready, frame_start, clear_err, rd_idx,
    input  rd_data, cfg_valid, frame_commit, busy, seq_err, tmo_err, ovr_err
  );

  modport slave (
    input  update_reg, idx, read_data, pc_ready, frame_start, clear_err, rd_idx,
    output rd_data, cfg_valid, frame_commit, busy, seq_err, tmo_err, ovr_err
  );
endinterface

// File: rtl/cfg_bank_ctrl.sv
// Double-buffered config bank: packets load into the shadow bank, and the banks swap on the
// first frame_start after a complete packet, so a frame only ever reads a whole packet.
module cfg_bank_ctrl #(
  parameter int NBYTES      = 55,
  parameter int IDXW        = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  cfg_bank_ctrl_if.slave    bus
);
  localparam int EXPW = $clog2(NBYTES + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int CW   = (IDXW > EXPW) ? IDXW : EXPW;

  localparam logic [EXPW-1:0] EXP_FULL = EXPW'(NBYTES);
  localparam logic [IDXW:0]   RD_LIM   = (IDXW + 1)'(NBYTES);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            act_sel, act_sel_n;
  logic [EXPW-1:0] exp, exp_n;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_n;
  logic            cfg_valid_q, cfg_valid_n;
  logic            frame_commit_q, frame_commit_n;
  logic            seq_err_q, tmo_err_q, ovr_err_q;
  logic            set_seq, set_tmo, set_ovr;
  logic            wr_en;
  logic [IDXW-1:0] wr_addr;

  logic [7:0] bank0 [NBYTES];
  logic [7:0] bank1 [NBYTES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      act_sel        <= 1'b0;
      exp            <= '0;
      tmo_cnt        <= '0;
      cfg_valid_q    <= 1'b0;
      frame_commit_q <= 1'b0;
      seq_err_q      <= 1'b0;
      tmo_err_q      <= 1'b0;
      ovr_err_q      <= 1'b0;
    end else begin
      state          <= state_n;
      act_sel        <= act_sel_n;
      exp            <= exp_n;
      tmo_cnt        <= tmo_cnt_n;
      cfg_valid_q    <= cfg_valid_n;
      frame_commit_q <= frame_commit_n;
      // a set event in the same cycle as clear_err keeps the flag up
      seq_err_q      <= set_seq | (seq_err_q & ~bus.clear_err);
      tmo_err_q      <= set_tmo | (tmo_err_q & ~bus.clear_err);
      ovr_err_q      <= set_ovr | (ovr_err_q & ~bus.clear_err);
    end
  end

  always_comb begin
    state_n        = state;
    act_sel_n      = act_sel;
    exp_n          = exp;
    tmo_cnt_n      = tmo_cnt;
    cfg_valid_n    = cfg_valid_q;
    frame_commit_n = 1'b0;
    set_seq        = 1'b0;
    set_tmo        = 1'b0;
    set_ovr        = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;

    unique case (state)
      IDLE: begin
        if (bus.update_reg) begin
          if (bus.idx == '0) begin
            wr_en     = 1'b1;
            exp_n     = EXPW'(1);
            tmo_cnt_n = '0;
            state_n   = LOAD;
          end else begin
            set_seq = 1'b1;
          end
        end
      end

      LOAD: begin
        if (bus.update_reg && bus.pc_ready) begin
          set_seq = 1'b1;
          state_n = IDLE;
        end else if (bus.update_reg) begin
          if (CW'(bus.idx) == CW'(exp) && exp < EXP_FULL) begin
            wr_en     = 1'b1;
            wr_addr   = IDXW'(exp);
            exp_n     = exp + 1'b1;
            tmo_cnt_n = '0;
          end else begin
            set_seq = 1'b1;
            state_n = IDLE;
          end
        end else if (bus.pc_ready) begin
          if (exp == EXP_FULL) begin
            state_n = PEND;
          end else begin
            set_seq = 1'b1;
            state_n = IDLE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          set_tmo = 1'b1;
          state_n = IDLE;
        end else if (tmo_cnt != {TW{1'b1}}) begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end

      PEND: begin
        if (bus.update_reg) begin
          set_ovr = 1'b1;
        end
        if (bus.frame_start) begin
          act_sel_n      = ~act_sel;
          cfg_valid_n    = 1'b1;
          frame_commit_n = 1'b1;
          state_n        = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // banks hold data only; the shadow is the one act_sel is not pointing at
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (act_sel) begin
        bank0[wr_addr] <= bus.read_data;
      end else begin
        bank1[wr_addr] <= bus.read_data;
      end
    end
  end

  always_comb begin
    bus.rd_data = 8'h00;
    if (cfg_valid_q && ({1'b0, bus.rd_idx} < RD_LIM)) begin
      bus.rd_data = act_sel ? bank1[bus.rd_idx] : bank0[bus.rd_idx];
    end
  end

  assign bus.cfg_valid    = cfg_valid_q;
  assign bus.frame_commit = frame_commit_q;
  assign bus.busy         = (state != IDLE);
  assign bus.seq_err      = seq_err_q;
  assign bus.tmo_err      = tmo_err_q;
  assign bus.ovr_err      = ovr_err_q;
endmodule

// File: tb/tb_cfg_bank_ctrl.sv
// Directed bench for cfg_bank_ctrl; the timeout is shortened to keep the idle-abort case brief.
module tb_cfg_bank_ctrl;
  localparam int NB   = 55;
  localparam int IW   = 6;
  localparam int TMO  = 40;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  cfg_bank_ctrl_if #(.IDXW(IW)) bus ();

  cfg_bank_ctrl #(
    .NBYTES      (NB),
    .IDXW        (IW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input int i, input logic [7:0] d);
    bus.update_reg = 1'b1;
    bus.idx        = IW'(i);
    bus.read_data  = d;
    tick();
    bus.update_reg = 1'b0;
  endtask

  task automatic pulse_pc();
    bus.pc_ready = 1'b1;
    tick();
    bus.pc_ready = 1'b0;
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
  endtask

  task automatic rd(input int a, input string tag, input logic [7:0] expv);
    bus.rd_idx = IW'(a);
    #1;
    chk(tag, {24'h0, bus.rd_data}, {24'h0, expv});
  endtask

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.update_reg  = 1'b0;
    bus.idx         = '0;
    bus.read_data   = 8'h00;
    bus.pc_ready    = 1'b0;
    bus.frame_start = 1'b0;
    bus.clear_err   = 1'b0;
    bus.rd_idx      = '0;
    tick();
    tick();

    chk("rst_busy",      bus.busy,         0);
    chk("rst_cfg_valid", bus.cfg_valid,    0);
    chk("rst_commit",    bus.frame_commit, 0);
    chk("rst_errs",      {bus.seq_err, bus.tmo_err, bus.ovr_err}, 0);
    reset = 1'b0;
    tick();

    // packet A, commit on frame_start
    for (int i = 0; i < NB; i++) send_byte(i, 8'(i) ^ 8'hA5);
    chk("a_busy_load", bus.busy, 1);
    pulse_pc();
    chk("a_busy_pend", bus.busy, 1);
    chk("a_valid_pre", bus.cfg_valid, 0);
    pulse_fs();
    chk("a_commit",    bus.frame_commit, 1);
    chk("a_valid",     bus.cfg_valid,    1);
    chk("a_busy_idle", bus.busy,         0);
    rd(10, "a_rd10", 8'hAF);
    rd(54, "a_rd54", 8'h93);
    rd(60, "a_rd60", 8'h00);
    tick();
    chk("a_commit_off", bus.frame_commit, 0);

    // packet B held in PEND until frame_start
    for (int i = 0; i < NB; i++) send_byte(i, 8'h30 + 8'(i));
    pulse_pc();
    tick();
    tick();
    rd(0, "b_hold_rd0", 8'hA5);
    chk("b_hold_busy", bus.busy, 1);
    chk("b_hold_commit", bus.frame_commit, 0);
    pulse_fs();
    rd(0,  "b_rd0",  8'h30);
    rd(54, "b_rd54", 8'h66);

    // out-of-order index
    send_byte(0, 8'h01);
    send_byte(1, 8'h02);
    send_byte(3, 8'h03);
    chk("seq_err_set", bus.seq_err, 1);
    chk("seq_busy",    bus.busy,    0);
    rd(0, "seq_rd0", 8'h30);
    pulse_clr();
    chk("seq_err_clr", bus.seq_err, 0);

    // non-zero index in IDLE together with clear_err: set wins
    bus.clear_err = 1'b1;
    send_byte(5, 8'h55);
    bus.clear_err = 1'b0;
    chk("seq_set_wins", bus.seq_err, 1);
    chk("idle_drop_busy", bus.busy, 0);
    pulse_clr();
    chk("seq_err_clr2", bus.seq_err, 0);

    // short packet
    for (int i = 0; i < 5; i++) send_byte(i, 8'hEE);
    pulse_pc();
    chk("short_seq", bus.seq_err, 1);
    chk("short_busy", bus.busy, 0);
    pulse_clr();

    // inter-byte timeout: abort on the TMO-th idle cycle
    for (int i = 0; i < 10; i++) send_byte(i, 8'h77);
    repeat (TMO - 1) tick();
    chk("tmo_before_busy", bus.busy,    1);
    chk("tmo_before_err",  bus.tmo_err, 0);
    tick();
    chk("tmo_err",  bus.tmo_err, 1);
    chk("tmo_busy", bus.busy,    0);
    pulse_pc();
    chk("tmo_pc_busy", bus.busy,    0);
    chk("tmo_pc_seq",  bus.seq_err, 0);
    chk("tmo_valid",   bus.cfg_valid, 1);
    rd(0, "tmo_rd0", 8'h30);
    pulse_clr();
    chk("tmo_clr", bus.tmo_err, 0);

    // byte arriving together with the swapping frame_start
    for (int i = 0; i < NB; i++) send_byte(i, ~8'(i));
    pulse_pc();
    bus.frame_start = 1'b1;
    send_byte(0, 8'h11);
    bus.frame_start = 1'b0;
    chk("ovr_err",    bus.ovr_err,      1);
    chk("ovr_commit", bus.frame_commit, 1);
    chk("ovr_busy",   bus.busy,         0);
    rd(0, "ovr_rd0", 8'hFF);
    rd(5, "ovr_rd5", 8'hFA);
    pulse_fs();
    chk("idle_fs_commit", bus.frame_commit, 0);
    rd(0, "idle_fs_rd0", 8'hFF);
    pulse_clr();
    chk("ovr_clr", bus.ovr_err, 0);

    // asynchronous reset in the middle of a packet
    for (int i = 0; i <= 20; i++) send_byte(i, 8'h42);
    chk("mid_busy", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy",   bus.busy,         0);
    chk("arst_valid",  bus.cfg_valid,    0);
    chk("arst_commit", bus.frame_commit, 0);
    tick();
    reset = 1'b0;
    tick();
    pulse_pc();
    pulse_fs();
    chk("arst_no_commit", bus.frame_commit, 0);
    chk("arst_no_valid",  bus.cfg_valid,    0);
    chk("arst_idle",      bus.busy,         0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
